mem_responder: RTL and testbench

//  Memory-side responder for the memory stage's load/store requests. Accepts one

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_array.sv | 46 ++++
 rtl/mem_responder.sv | 109 ++++++++++
 tb/tb_mem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory-stage responder.
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

endpackage

// File: rtl/mem_array.sv
// Word storage: one write port, one registered read port, synchronous clear.
module mem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_dump,
  output logic [DATA_W-1:0]        o_rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i[IDX_W-1:0]] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      // Read register only moves on a read, so it holds the last read word.
      if (i_re) r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (!i_rst && i_dump) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        $display("MEMDUMP %0h: %0h", i, r_mem[i]);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one outstanding word read or write, done/err pulses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  input  logic              createdump,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_e            r_state;
  state_e            w_state_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_d;
  op_e               r_op;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;

  logic w_req_ok;
  logic w_req_bad;
  logic w_we;
  logic w_re;
  logic w_unused_addr;

  assign w_req_ok      = (rd ^ wr) & ~addr[0];
  assign w_req_bad     = (rd & wr) | ((rd | wr) & addr[0]);
  assign w_unused_addr = ^addr[ADDR_W-1:IDX_W+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_op    <= OP_RD;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_err   <= (r_state == IDLE) & w_req_bad;
      if (r_state == IDLE && w_req_ok) begin
        r_op    <= wr ? OP_WR : OP_RD;
        r_idx   <= addr[IDX_W:1];
        r_wdata <= data_in;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_we      = 1'b0;
    w_re      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_ok) begin
          w_state_d = BUSY;
          w_cnt_d   = CNT_W'(LAT - 1);
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_we      = (r_op == OP_WR);
          w_re      = (r_op == OP_RD);
          w_state_d = RESP;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .i_dump  (createdump && (r_state == IDLE)),
    .o_rdata (data_out)
  );

  assign stall = (r_state != IDLE);
  assign done  = (r_state == RESP);
  assign err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; three instances cover LAT = 2, 1 and 4.
module tb_mem_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        exp_err;
    logic [15:0] exp_dout;
  } vec_t;

  logic        clk;
  logic        t_dump;
  logic        t_rst  [3];
  logic        t_rd   [3];
  logic        t_wr   [3];
  logic [15:0] t_addr [3];
  logic [15:0] t_din  [3];
  logic [15:0] t_dout [3];
  logic        t_stall[3];
  logic        t_done [3];
  logic        t_err  [3];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    mem_responder #(
      .ADDR_W (16),
      .DATA_W (16),
      .DEPTH  (256),
      .LAT    (L)
    ) u_dut (
      .clk        (clk),
      .rst        (t_rst[g]),
      .addr       (t_addr[g]),
      .data_in    (t_din[g]),
      .rd         (t_rd[g]),
      .wr         (t_wr[g]),
      .createdump (t_dump),
      .data_out   (t_dout[g]),
      .stall      (t_stall[g]),
      .done       (t_done[g]),
      .err        (t_err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Presents a request, holds it while stalled, drops it on done/err; bounded to 8 cycles.
  task automatic run_txn(input int k, input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic corrupt, output int n_stall,
                         output int n_done, output int n_err, output int done_at,
                         output int n_both);
    @(negedge clk);
    t_rd[k] = rd; t_wr[k] = wr; t_addr[k] = a; t_din[k] = d;
    n_stall = 0; n_done = 0; n_err = 0; n_both = 0; done_at = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (corrupt && t_stall[k]) begin
        t_addr[k] = a ^ 16'h0008;
        t_din[k]  = 16'hDEAD;
      end
      n_stall += int'(t_stall[k]);
      n_err   += int'(t_err[k]);
      if (t_done[k]) begin
        n_done++;
        done_at = c;
      end
      if (t_done[k] && t_err[k]) n_both++;
      if (t_done[k] || t_err[k]) begin
        t_rd[k] = 1'b0;
        t_wr[k] = 1'b0;
      end
    end
  endtask

  vec_t vecs[13];
  int   ns, nd, ne, da, nb;

  initial begin
    checks = 0; failures = 0; t_dump = 1'b0;
    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'hBEEF};
    vecs[3]  = '{1'b1, 1'b1, 16'h0020, 16'h1111, 1'b1, 16'hBEEF};
    vecs[4]  = '{1'b0, 1'b1, 16'h0011, 16'h2222, 1'b1, 16'hBEEF};
    vecs[5]  = '{1'b0, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'hBEEF};
    vecs[6]  = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 16'hA5A5};
    vecs[7]  = '{1'b0, 1'b1, 16'h01FE, 16'h7777, 1'b0, 16'hA5A5};
    vecs[8]  = '{1'b1, 1'b0, 16'h03FE, 16'h0000, 1'b0, 16'h7777};
    vecs[9]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    vecs[10] = '{1'b0, 1'b1, 16'h0010, 16'h0F0F, 1'b0, 16'hBEEF};
    vecs[11] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000};
    vecs[12] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0F0F};

    for (int k = 0; k < 3; k++) begin
      t_rst[k] = 1'b1; t_rd[k] = 1'b0; t_wr[k] = 1'b0; t_addr[k] = '0; t_din[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) t_rst[k] = 1'b0;
    @(negedge clk);
    check("reset_stall", 32'(t_stall[0]), 32'd0);
    check("reset_done", 32'(t_done[0]), 32'd0);
    check("reset_err", 32'(t_err[0]), 32'd0);
    check("reset_dout", 32'(t_dout[0]), 32'h0);

    for (int i = 0; i < 13; i++) begin
      run_txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, 1'b0, ns, nd, ne, da, nb);
      check($sformatf("vec%0d_err", i), 32'(ne), vecs[i].exp_err ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_done", i), 32'(nd), vecs[i].exp_err ? 32'd0 : 32'd1);
      check($sformatf("vec%0d_stall", i), 32'(ns), vecs[i].exp_err ? 32'd0 : 32'd3);
      if (!vecs[i].exp_err) check($sformatf("vec%0d_done_at", i), 32'(da), 32'd3);
      check($sformatf("vec%0d_both", i), 32'(nb), 32'd0);
      check($sformatf("vec%0d_dout", i), 32'(t_dout[0]), 32'(vecs[i].exp_dout));
    end

    // Reset mid-BUSY aborts the pending write.
    @(negedge clk);
    t_wr[0] = 1'b1; t_addr[0] = 16'h0002; t_din[0] = 16'h1234;
    @(negedge clk);
    check("abort_busy", 32'(t_stall[0]), 32'd1);
    t_rst[0] = 1'b1; t_wr[0] = 1'b0;
    @(negedge clk);
    t_rst[0] = 1'b0;
    check("abort_stall", 32'(t_stall[0]), 32'd0);
    check("abort_dout", 32'(t_dout[0]), 32'h0);
    run_txn(0, 1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, ns, nd, ne, da, nb);
    check("abort_rd_done", 32'(nd), 32'd1);
    check("abort_rd_dout", 32'(t_dout[0]), 32'h0);

    // Inputs changed while stalled must not leak into the transaction.
    for (int k = 0; k < 3; k++) begin
      run_txn(k, 1'b0, 1'b1, 16'h0004, 16'h5555, 1'b1, ns, nd, ne, da, nb);
      check($sformatf("hold%0d_done_at", k), 32'(da), 32'(lat_of(k) + 1));
      check($sformatf("hold%0d_stall", k), 32'(ns), 32'(lat_of(k) + 1));
      run_txn(k, 1'b1, 1'b0, 16'h0004, 16'h0, 1'b0, ns, nd, ne, da, nb);
      check($sformatf("hold%0d_rd_done_at", k), 32'(da), 32'(lat_of(k) + 1));
      check($sformatf("hold%0d_rd", k), 32'(t_dout[k]), 32'h5555);
      run_txn(k, 1'b1, 1'b0, 16'h000C, 16'h0, 1'b0, ns, nd, ne, da, nb);
      check($sformatf("hold%0d_alt", k), 32'(t_dout[k]), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
